// File: rtl/path_count_engine.sv
// Counts source-to-target paths in a DAG by propagating path weights through a merging work queue.
// Successor lists are fetched over a ready/valid request/response pair, one successor per beat.
module path_count_engine #(
    parameter int unsigned NODE_IDX_WIDTH = 10,
    parameter int unsigned ACCUM_WIDTH    = 48,
    parameter int unsigned QUEUE_DEPTH    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NODE_IDX_WIDTH-1:0] start_node,
    input  logic [NODE_IDX_WIDTH-1:0] end_node,
    output logic                      adj_req_valid,
    input  logic                      adj_req_ready,
    output logic [NODE_IDX_WIDTH-1:0] adj_req_node,
    input  logic                      adj_rsp_valid,
    output logic                      adj_rsp_ready,
    input  logic [NODE_IDX_WIDTH-1:0] adj_rsp_node,
    input  logic                      adj_rsp_last,
    input  logic                      adj_rsp_none,
    output logic                      busy,
    output logic                      done,
    output logic [ACCUM_WIDTH-1:0]    path_count,
    output logic                      count_sat,
    output logic                      queue_ovf
);
    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);

    typedef logic [PtrW-1:0]           ptr_t;
    typedef logic [ACCUM_WIDTH-1:0]    cnt_t;
    typedef logic [NODE_IDX_WIDTH-1:0] node_t;
    typedef enum logic [1:0] {StIdle, StReq, StRsp, StFinish} state_e;

    state_e                 state_q, state_d;
    node_t                  q_node_q [QUEUE_DEPTH];
    node_t                  q_node_d [QUEUE_DEPTH];
    cnt_t                   q_cnt_q  [QUEUE_DEPTH];
    cnt_t                   q_cnt_d  [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_vld_q, q_vld_d;
    ptr_t                   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    node_t                  end_q, end_d;
    cnt_t                   acc_q, acc_d, weight_q, weight_d;
    cnt_t                   path_count_q, path_count_d;
    logic                   done_q, done_d, sat_q, sat_d, ovf_q, ovf_d;

    logic                   q_full, q_empty, hit, push_drop;
    ptr_t                   hit_idx;
    logic [ACCUM_WIDTH:0]   sum;

    // MSB of the result flags that the addition clamped.
    function automatic logic [ACCUM_WIDTH:0] add_sat(input cnt_t a, input cnt_t b);
        logic [ACCUM_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ACCUM_WIDTH]) s = {1'b1, {ACCUM_WIDTH{1'b1}}};
        return s;
    endfunction

    assign q_full        = (rd_ptr_q == wr_ptr_q) && q_vld_q[rd_ptr_q];
    assign q_empty       = (rd_ptr_q == wr_ptr_q) && !q_vld_q[rd_ptr_q];
    assign adj_req_node  = q_node_q[rd_ptr_q];
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign path_count    = path_count_q;
    assign count_sat     = sat_q;
    assign queue_ovf     = ovf_q;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            if (!hit && q_vld_q[i] && (q_node_q[i] == adj_rsp_node)) begin
                hit     = 1'b1;
                hit_idx = ptr_t'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        q_node_d      = q_node_q;
        q_cnt_d       = q_cnt_q;
        q_vld_d       = q_vld_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        end_d         = end_q;
        acc_d         = acc_q;
        weight_d      = weight_q;
        path_count_d  = path_count_q;
        done_d        = 1'b0;
        sat_d         = sat_q;
        ovf_d         = ovf_q;
        adj_req_valid = 1'b0;
        adj_rsp_ready = 1'b0;
        push_drop     = 1'b0;
        sum           = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    q_vld_d     = '0;
                    q_vld_d[0]  = 1'b1;
                    q_node_d[0] = start_node;
                    q_cnt_d[0]  = cnt_t'(1);
                    rd_ptr_d    = '0;
                    wr_ptr_d    = ptr_t'(1);
                    end_d       = end_node;
                    sat_d       = 1'b0;
                    ovf_d       = 1'b0;
                    if (start_node == end_node) begin
                        acc_d   = cnt_t'(1);
                        state_d = StFinish;
                    end else begin
                        acc_d   = '0;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (q_empty) begin
                    state_d = StFinish;
                end else begin
                    adj_req_valid = 1'b1;
                    if (adj_req_ready) begin
                        weight_d          = q_cnt_q[rd_ptr_q];
                        q_vld_d[rd_ptr_q] = 1'b0;
                        rd_ptr_d          = rd_ptr_q + ptr_t'(1);
                        state_d           = StRsp;
                    end
                end
            end
            StRsp: begin
                adj_rsp_ready = 1'b1;
                if (adj_rsp_valid) begin
                    if (!adj_rsp_none) begin
                        if (adj_rsp_node == end_q) begin
                            sum   = add_sat(acc_q, weight_q);
                            acc_d = sum[ACCUM_WIDTH-1:0];
                        end else if (hit) begin
                            sum              = add_sat(q_cnt_q[hit_idx], weight_q);
                            q_cnt_d[hit_idx] = sum[ACCUM_WIDTH-1:0];
                        end else if (q_full) begin
                            push_drop = 1'b1;
                            ovf_d     = 1'b1;
                        end else begin
                            q_node_d[wr_ptr_q] = adj_rsp_node;
                            q_cnt_d[wr_ptr_q]  = weight_q;
                            q_vld_d[wr_ptr_q]  = 1'b1;
                            wr_ptr_d           = wr_ptr_q + ptr_t'(1);
                        end
                        sat_d = sat_q | sum[ACCUM_WIDTH];
                    end
                    if (push_drop) state_d = StFinish;
                    else if (adj_rsp_last) state_d = StReq;
                end
            end
            StFinish: begin
                path_count_d = acc_q;
                done_d       = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            q_vld_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            end_q        <= '0;
            acc_q        <= '0;
            weight_q     <= '0;
            path_count_q <= '0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_vld_q      <= q_vld_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            end_q        <= end_d;
            acc_q        <= acc_d;
            weight_q     <= weight_d;
            path_count_q <= path_count_d;
            done_q       <= done_d;
            sat_q        <= sat_d;
            ovf_q        <= ovf_d;
        end
    end

    // Payload storage needs no reset; validity is tracked in q_vld_q.
    always_ff @(posedge clk) begin
        q_node_q <= q_node_d;
        q_cnt_q  <= q_cnt_d;
    end

endmodule

// File: tb/tb_path_count_engine.sv
// Bench for path_count_engine: directed graphs plus random DAGs with random handshake stalls,
// checked against a queue-based reference model of the traversal rules.
module tb_path_count_engine;
    localparam int NW   = 10;
    localparam int AW   = 4;
    localparam int QD   = 4;
    localparam int MAXC = 15;
    localparam int NN   = 16;
    localparam int MAXS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NW-1:0] start_node = '0;
    logic [NW-1:0] end_node = '0;
    logic          adj_req_valid;
    logic          adj_req_ready = 1'b0;
    logic [NW-1:0] adj_req_node;
    logic          adj_rsp_valid = 1'b0;
    logic          adj_rsp_ready;
    logic [NW-1:0] adj_rsp_node = '0;
    logic          adj_rsp_last = 1'b0;
    logic          adj_rsp_none = 1'b0;
    logic          busy, done, count_sat, queue_ovf;
    logic [AW-1:0] path_count;

    int errors = 0;
    int checks = 0;
    int adj_n [NN];
    int adj_s [NN][MAXS];
    int req_hist [NN];
    int last_lat;
    bit last_saw;
    bit m_sat;

    typedef struct {int node; int cnt;} ent_t;

    path_count_engine #(
        .NODE_IDX_WIDTH(NW),
        .ACCUM_WIDTH   (AW),
        .QUEUE_DEPTH   (QD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_node   (start_node),
        .end_node     (end_node),
        .adj_req_valid(adj_req_valid),
        .adj_req_ready(adj_req_ready),
        .adj_req_node (adj_req_node),
        .adj_rsp_valid(adj_rsp_valid),
        .adj_rsp_ready(adj_rsp_ready),
        .adj_rsp_node (adj_rsp_node),
        .adj_rsp_last (adj_rsp_last),
        .adj_rsp_none (adj_rsp_none),
        .busy         (busy),
        .done         (done),
        .path_count   (path_count),
        .count_sat    (count_sat),
        .queue_ovf    (queue_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_req_valid"}, 64'(adj_req_valid), 0);
        check({tag, "_rsp_ready"}, 64'(adj_rsp_ready), 0);
        check({tag, "_path_count"}, 64'(path_count), 0);
        check({tag, "_count_sat"}, 64'(count_sat), 0);
        check({tag, "_queue_ovf"}, 64'(queue_ovf), 0);
    endtask

    task automatic clear_graph();
        for (int i = 0; i < NN; i++) adj_n[i] = 0;
    endtask

    task automatic add_edge(input int u, input int v);
        adj_s[u][adj_n[u]] = v;
        adj_n[u]++;
    endtask

    function automatic int sadd(input int a, input int b);
        int r = a + b;
        if (r > MAXC) begin
            r = MAXC;
            m_sat = 1'b1;
        end
        return r;
    endfunction

    // Weight propagation through a bounded FIFO with merge-on-membership.
    task automatic model(input int s, input int e, output int pc, output bit sat, output bit ovf);
        ent_t q[$];
        ent_t h;
        int   acc = 0;
        m_sat = 1'b0;
        ovf   = 1'b0;
        if (s == e) begin
            pc  = 1;
            sat = 1'b0;
            return;
        end
        q.push_back('{s, 1});
        while (q.size() > 0 && !ovf) begin
            h = q.pop_front();
            for (int k = 0; k < adj_n[h.node] && !ovf; k++) begin
                int  t   = adj_s[h.node][k];
                bit  hit = 1'b0;
                if (t == e) begin
                    acc = sadd(acc, h.cnt);
                end else begin
                    foreach (q[i]) if (q[i].node == t) begin
                        q[i].cnt = sadd(q[i].cnt, h.cnt);
                        hit = 1'b1;
                    end
                    if (!hit) begin
                        if (q.size() >= QD) ovf = 1'b1;
                        else q.push_back('{t, h.cnt});
                    end
                end
            end
        end
        pc  = acc;
        sat = m_sat;
    endtask

    // Drives one run; acts as adjacency server. abort_after > 0 returns once that many
    // response beats have been handed over, leaving the engine mid-run.
    task automatic run(input int s, input int e, input int stall, input bit poke,
                       input int abort_after, output bit got_done, output int lat,
                       output bit saw_req);
        int  b_node[$];
        bit  b_last[$];
        bit  b_none[$];
        bit  prev_stall = 1'b0;
        int  prev_node = 0;
        int  fired = 0;
        got_done = 1'b0;
        lat      = 0;
        saw_req  = 1'b0;
        for (int i = 0; i < NN; i++) req_hist[i] = 0;
        @(negedge clk);
        start         = 1'b1;
        start_node    = NW'(s);
        end_node      = NW'(e);
        adj_req_ready = 1'b0;
        adj_rsp_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                if (poke && cyc == 3) begin
                    check("busy_at_poke", 64'(busy), 1);
                    start      = 1'b1;
                    start_node = NW'(3);
                    end_node   = NW'(3);
                end
                if (prev_stall) begin
                    check("req_hold_valid", 64'(adj_req_valid), 1);
                    check("req_hold_node", 64'(adj_req_node), 64'(prev_node));
                end
                if (adj_req_valid === 1'b1) saw_req = 1'b1;
                adj_req_ready = ($urandom_range(99) >= stall);
                if (b_node.size() > 0 && $urandom_range(99) >= stall) begin
                    adj_rsp_valid = 1'b1;
                    adj_rsp_node  = NW'(b_node[0]);
                    adj_rsp_last  = b_last[0];
                    adj_rsp_none  = b_none[0];
                end else begin
                    adj_rsp_valid = 1'b0;
                    adj_rsp_node  = NW'($urandom);
                    adj_rsp_last  = 1'($urandom);
                    adj_rsp_none  = 1'($urandom);
                end
                prev_stall = adj_req_valid && !adj_req_ready;
                prev_node  = int'(adj_req_node);
                if (adj_req_valid && adj_req_ready) begin
                    int n = int'(adj_req_node);
                    if (n < NN) req_hist[n]++;
                    if (n >= NN || adj_n[n] == 0) begin
                        b_node.push_back(int'($urandom_range(1023)));
                        b_last.push_back(1'b1);
                        b_none.push_back(1'b1);
                    end else begin
                        for (int k = 0; k < adj_n[n]; k++) begin
                            b_node.push_back(adj_s[n][k]);
                            b_last.push_back(k == adj_n[n] - 1);
                            b_none.push_back(1'b0);
                        end
                    end
                end
                if (adj_rsp_valid && adj_rsp_ready) begin
                    void'(b_node.pop_front());
                    void'(b_last.pop_front());
                    void'(b_none.pop_front());
                    fired++;
                    if (abort_after > 0 && fired >= abort_after) return;
                end
            end
        end
        adj_req_ready = 1'b0;
        adj_rsp_valid = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int s, input int e, input int stall,
                                 input bit poke, input int exp_pc, input bit exp_sat,
                                 input bit exp_ovf);
        bit got;
        int lat;
        bit saw;
        run(s, e, stall, poke, 0, got, lat, saw);
        last_lat = lat;
        last_saw = saw;
        check({tag, "_done_seen"}, 64'(got), 1);
        check({tag, "_path_count"}, 64'(path_count), 64'(exp_pc));
        check({tag, "_count_sat"}, 64'(count_sat), 64'(exp_sat));
        check({tag, "_queue_ovf"}, 64'(queue_ovf), 64'(exp_ovf));
        check({tag, "_idle_at_done"}, 64'(busy), 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 0);
        repeat (2) @(negedge clk);
        check({tag, "_count_held"}, 64'(path_count), 64'(exp_pc));
    endtask

    task automatic graph_simple();
        clear_graph();
        add_edge(0, 1);
        add_edge(0, 2);
        add_edge(1, 3);
        add_edge(2, 3);
    endtask

    initial begin
        bit got;
        int lat;
        bit saw;
        int pc;
        bit sat;
        bit ovf;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        graph_simple();
        run_and_check("simple", 0, 3, 0, 1'b1, 2, 1'b0, 1'b0);

        clear_graph();
        add_edge(0, 1);
        add_edge(0, 2);
        add_edge(1, 2);
        add_edge(1, 4);
        add_edge(2, 4);
        run_and_check("diamond", 0, 4, 0, 1'b0, 3, 1'b0, 1'b0);
        check("diamond_node2_requests", 64'(req_hist[2]), 1);
        check("diamond_end_not_requested", 64'(req_hist[4]), 0);

        run_and_check("same_node", 5, 5, 0, 1'b0, 1, 1'b0, 1'b0);
        check("same_node_no_req", 64'(last_saw), 0);
        check("same_node_latency", 64'(last_lat), 2);

        clear_graph();
        for (int v = 1; v <= 6; v++) add_edge(0, v);
        run_and_check("fanout_ovf", 0, 9, 20, 1'b0, 0, 1'b0, 1'b1);

        clear_graph();
        add_edge(0, 1);
        add_edge(0, 2);
        for (int l = 0; l < 4; l++) begin
            for (int a = 0; a < 2; a++) begin
                add_edge(2 * l + 1 + a, 2 * l + 3);
                add_edge(2 * l + 1 + a, 2 * l + 4);
            end
        end
        add_edge(9, 11);
        add_edge(10, 11);
        run_and_check("layered_sat", 0, 11, 0, 1'b0, 15, 1'b1, 1'b0);

        graph_simple();
        run(0, 3, 40, 1'b0, 1, got, lat, saw);
        @(negedge clk);
        rst           = 1'b1;
        adj_rsp_valid = 1'b0;
        adj_req_ready = 1'b0;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_reset", 64'(done), 0);
        end
        run_and_check("rerun", 0, 3, 40, 1'b0, 2, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            int s;
            int e;
            clear_graph();
            for (int u = 0; u < 7; u++) begin
                int n = int'($urandom_range(3));
                for (int k = 0; k < n; k++) add_edge(u, int'($urandom_range(7, u + 1)));
            end
            s = int'($urandom_range(2));
            e = int'($urandom_range(7));
            model(s, e, pc, sat, ovf);
            run_and_check($sformatf("rand%0d", t), s, e, int'($urandom_range(50)), 1'b0,
                          pc, sat, ovf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/path_count_engine.md
PATH_COUNT_ENGINE -- requirements
Module: path_count_engine

Interface
REQ-001 SHALL have parameter NODE_IDX_WIDTH, default 10, node index width.
REQ-002 SHALL have parameter ACCUM_WIDTH, default 48, path-count width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 64, power of two >= 2, work-queue entries.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle run request; sampled only in IDLE.
REQ-007 SHALL have port start_node  in  NODE_IDX_WIDTH  source node; sampled with start.
REQ-008 SHALL have port end_node  in  NODE_IDX_WIDTH  target node; sampled with start.
REQ-009 SHALL have ports adj_req_valid out 1, adj_req_ready in 1, adj_req_node out NODE_IDX_WIDTH: successor-list request.
REQ-010 SHALL have ports adj_rsp_valid in 1, adj_rsp_ready out 1, adj_rsp_node in NODE_IDX_WIDTH, adj_rsp_last in 1, adj_rsp_none in 1: one successor per beat; none=1 marks a successor-less node, with that beat's node ignored and last=1.
REQ-011 SHALL have outputs busy 1, done 1 (pulse), path_count ACCUM_WIDTH, count_sat 1, queue_ovf 1.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, RSP, FINISH.
REQ-013 IDLE: start=1 latches start_node/end_node, clears queue, end accumulator, count_sat and queue_ovf, then pushes {start_node, 1} and moves to REQ next cycle.
REQ-014 start_node==end_node SHALL skip traversal: FINISH with path_count=1.
REQ-015 start asserted outside IDLE SHALL be ignored.
REQ-016 REQ: queue empty -> FINISH; else adj_req_valid=1 with adj_req_node = head node index; on valid&ready pop head (count retained as current weight) and go to RSP.
REQ-017 adj_req_valid/adj_req_node SHALL stay stable until accepted.
REQ-018 RSP: adj_rsp_ready=1; each valid&ready beat with none=0 SHALL process successor s with weight w in that same cycle.
REQ-019 s==end_node: end accumulator += w.
REQ-020 s matches a valid queue entry: that entry's count += w; no push.
REQ-021 Otherwise: push {s, w}.
REQ-022 Queue membership search SHALL be combinational over all QUEUE_DEPTH entries; entries are invalidated on pop.
REQ-023 The beat with last=1 (including none=1) returns FSM to REQ next cycle.
REQ-024 Additions SHALL saturate at 2^ACCUM_WIDTH-1; any saturation sets count_sat sticky until next start.
REQ-025 Push when queue full SHALL drop the push, set queue_ovf, and go to FINISH after the beat.
REQ-026 FINISH: path_count <= end accumulator (or 1 per REQ-014); done=1 for exactly one cycle; return to IDLE.
REQ-027 path_count, count_sat, queue_ovf SHALL hold until next accepted start.
REQ-028 busy=1 in every state except IDLE.
REQ-029 Read/write pointers SHALL wrap modulo QUEUE_DEPTH; full = ptrs equal and head valid; empty = ptrs equal and head invalid.
REQ-030 Ready/valid handshakes SHALL tolerate arbitrary back-pressure and idle cycles without data loss or duplication.

Reset
REQ-031 rst=1 at any clock edge SHALL force IDLE, clear queue valids and pointers, and drive busy=0, done=0, adj_req_valid=0, adj_rsp_ready=0, path_count=0, count_sat=0, queue_ovf=0.
REQ-032 Reset mid-run SHALL abandon the run with no done pulse; the first start after reset begins a clean run.

Verification
REQ-033 Graph 0->{1,2}, 1->{3}, 2->{3}, 3->none; start=0,end=3 -> done once, path_count=2, flags 0.
REQ-034 Diamond with re-queued node: 0->{1,2}, 1->{2,4}, 2->{4}, end=4 -> path_count=3, node 2 queued once (merge path).
REQ-035 start_node=end_node=5 -> no adj_req_valid, done two cycles after start, path_count=1.
REQ-036 QUEUE_DEPTH=4 with fan-out of 6 from start -> queue_ovf=1, done pulses, no hang.
REQ-037 ACCUM_WIDTH=4, layered graph of 2^5 paths -> path_count=15, count_sat=1.
REQ-038 Random ready/valid stalls on both channels plus rst asserted mid-RSP -> outputs at reset values; rerun of REQ-033 gives 2.
